// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/control unit: select codes, slot flag layout,
// depth bounds and the slot-to-select mapping.
package hazard_ctrl_pkg;

  // Select code meaning "take the operand from the register file"
  localparam int FWD_RF    = 0;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 6;

  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
  } slot_flags_t;

  // Slot k forwards through select code k+1; code 0 stays reserved for the register file.
  function automatic int fwd_code(input int slot);
    return slot + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/EX/MEM-facing signal bundle of the hazard/control unit.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic             de_valid;
  logic [REG_W-1:0] de_rs1;
  logic [REG_W-1:0] de_rs2;
  logic             de_use_rs1;
  logic             de_use_rs2;
  logic [REG_W-1:0] de_rd;
  logic             de_reg_write;
  logic             de_mem_read;
  logic             br_taken;
  logic             mem_busy;
  logic             stall_fetch;
  logic             stall_decode;
  logic             flush_decode;
  logic             bubble_ex;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd,
           de_reg_write, de_mem_read, br_taken, mem_busy,
    input  stall_fetch, stall_decode, flush_decode, bubble_ex,
           fwd_a_sel, fwd_b_sel, stall_cycles
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd,
           de_reg_write, de_mem_read, br_taken, mem_busy,
    output stall_fetch, stall_decode, flush_decode, bubble_ex,
           fwd_a_sel, fwd_b_sel, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_slot.sv
// One scoreboard slot: captures the entry shifted in from the younger side,
// holds while the memory stage is busy, clears on reset.
module hazard_slot
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  slot_flags_t      d_flags,
  input  logic [REG_W-1:0] d_rd,
  output slot_flags_t      q_flags,
  output logic [REG_W-1:0] q_rd
);

  slot_flags_t      flags_reg;
  logic [REG_W-1:0] rd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg <= '0;
      rd_reg    <= '0;
    end else if (!hold) begin
      flags_reg <= d_flags;
      rd_reg    <= d_rd;
    end
  end

  assign q_flags = flags_reg;
  assign q_rd    = rd_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/control unit for the 5-stage RV32I pipeline: scoreboards in-flight
// destinations and derives stall, flush, bubble, forwarding selects and a stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int FORWARD  = 1,
  parameter int LOAD_FWD = 1,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("hazard_ctrl: DEPTH out of range");
  end

  slot_flags_t      flags_q [DEPTH];
  slot_flags_t      flags_d [DEPTH];
  logic [REG_W-1:0] rd_q    [DEPTH];
  logic [REG_W-1:0] rd_d    [DEPTH];
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  logic             haz_a;
  logic             haz_b;
  logic [SEL_W-1:0] src_a;
  logic [SEL_W-1:0] src_b;
  logic             stall;
  logic             flush;

  logic [SEL_W-1:0] fwd_a_reg, fwd_a_next;
  logic [SEL_W-1:0] fwd_b_reg, fwd_b_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        // A stalled or flushed decode instruction enters EX as a bubble.
        assign flags_d[gi] = '{valid: hz.de_valid & ~stall & ~flush,
                               wr:    hz.de_reg_write,
                               load:  hz.de_mem_read};
        assign rd_d[gi]    = hz.de_rd;
      end else begin : g_tail
        assign flags_d[gi] = flags_q[gi-1];
        assign rd_d[gi]    = rd_q[gi-1];
      end

      hazard_slot #(.REG_W(REG_W)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .hold    (hz.mem_busy),
        .d_flags (flags_d[gi]),
        .d_rd    (rd_d[gi]),
        .q_flags (flags_q[gi]),
        .q_rd    (rd_q[gi])
      );

      assign match_a[gi] = flags_q[gi].valid & flags_q[gi].wr & (rd_q[gi] == hz.de_rs1)
                         & (hz.de_rs1 != '0) & hz.de_use_rs1;
      assign match_b[gi] = flags_q[gi].valid & flags_q[gi].wr & (rd_q[gi] == hz.de_rs2)
                         & (hz.de_rs2 != '0) & hz.de_use_rs2;
    end
  endgenerate

  // Scan oldest to youngest so the youngest producer is the one left standing.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    src_a = SEL_W'(FWD_RF);
    src_b = SEL_W'(FWD_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        haz_a = (FORWARD != 0) ? (flags_q[k].load && (k < LOAD_FWD)) : (k < DEPTH - 1);
        src_a = SEL_W'(fwd_code(k));
      end
      if (match_b[k]) begin
        haz_b = (FORWARD != 0) ? (flags_q[k].load && (k < LOAD_FWD)) : (k < DEPTH - 1);
        src_b = SEL_W'(fwd_code(k));
      end
    end
  end

  // A taken branch kills the decode instruction, so it never also stalls.
  assign stall = hz.de_valid & (haz_a | haz_b) & ~hz.br_taken & ~hz.mem_busy;
  assign flush = hz.br_taken & ~hz.mem_busy;

  assign hz.stall_fetch  = ~rst & (stall | hz.mem_busy);
  assign hz.stall_decode = ~rst & (stall | hz.mem_busy);
  assign hz.flush_decode = ~rst & flush;
  assign hz.bubble_ex    = ~rst & (stall | flush) & ~hz.mem_busy;

  always_comb begin
    fwd_a_next = fwd_a_reg;
    fwd_b_next = fwd_b_reg;
    cnt_next   = cnt_reg;
    if (!hz.mem_busy) begin
      // An empty EX slot (stall, flush or no decode instruction) reads the register file.
      if (FORWARD == 0 || stall || flush || !hz.de_valid) begin
        fwd_a_next = SEL_W'(FWD_RF);
        fwd_b_next = SEL_W'(FWD_RF);
      end else begin
        fwd_a_next = src_a;
        fwd_b_next = src_b;
      end
    end
    if (stall && cnt_reg != '1) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_reg <= '0;
      fwd_b_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign hz.fwd_a_sel    = fwd_a_reg;
  assign hz.fwd_b_sel    = fwd_b_reg;
  assign hz.stall_cycles = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a stall-only instance share one
// stimulus stream and are both checked every cycle against an age-ordered reference model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5), .DEPTH(3), .CNT_W(16)) if_f ();
  hazard_ctrl_if #(.REG_W(5), .DEPTH(3), .CNT_W(4))  if_s ();

  hazard_ctrl #(.REG_W(5), .DEPTH(3), .FORWARD(1), .LOAD_FWD(1), .CNT_W(16)) u_fwd (
    .clk (clk), .rst (rst), .hz (if_f)
  );
  hazard_ctrl #(.REG_W(5), .DEPTH(3), .FORWARD(0), .LOAD_FWD(1), .CNT_W(4)) u_stl (
    .clk (clk), .rst (rst), .hz (if_s)
  );

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Model: index 0 = forwarding instance, 1 = stall-only; age 0 is the instruction now in EX.
  bit m_v  [2][3];
  int m_rd [2][3];
  bit m_wr [2][3];
  bit m_ld [2][3];
  int m_sa [2];
  int m_sb [2];
  int m_cnt[2];
  int cnt_max[2] = '{65535, 15};

  bit i_v, i_u1, i_u2, i_wr, i_ld, i_br, i_busy;
  int i_rs1, i_rs2, i_rd;
  int ya[2], yb[2];
  bit e_stl[2];
  bit e_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) begin
        m_v[m][k] = 0; m_rd[m][k] = 0; m_wr[m][k] = 0; m_ld[m][k] = 0;
      end
      m_sa[m] = 0; m_sb[m] = 0; m_cnt[m] = 0;
    end
  endtask

  // Age of the youngest in-flight instruction producing rs, or -1.
  function automatic int youngest(input int m, input int rs, input bit use_rs);
    if (!use_rs || rs == 0) return -1;
    for (int k = 0; k < 3; k++)
      if (m_v[m][k] && m_wr[m][k] && m_rd[m][k] == rs) return k;
    return -1;
  endfunction

  // Forwarding: only a load still in EX is not yet available. Stall-only: anything before write-back.
  function automatic bit blocks(input int m, input int k);
    if (k < 0) return 0;
    if (m == 0) return m_ld[m][k] && (k < 1);
    return k < 2;
  endfunction

  task automatic mdl_clock(input int m);
    if (i_busy) return;
    if (m == 1 || e_stl[m] || e_fl || !i_v) begin
      m_sa[m] = 0; m_sb[m] = 0;
    end else begin
      m_sa[m] = ya[m] + 1; m_sb[m] = yb[m] + 1;
    end
    if (e_stl[m] && m_cnt[m] < cnt_max[m]) m_cnt[m]++;
    for (int k = 2; k > 0; k--) begin
      m_v[m][k] = m_v[m][k-1]; m_rd[m][k] = m_rd[m][k-1];
      m_wr[m][k] = m_wr[m][k-1]; m_ld[m][k] = m_ld[m][k-1];
    end
    m_v[m][0] = i_v && !e_stl[m] && !e_fl;
    m_rd[m][0] = i_rd; m_wr[m][0] = i_wr; m_ld[m][0] = i_ld;
  endtask

  task automatic drive();
    if_f.de_valid = i_v;      if_s.de_valid = i_v;
    if_f.de_rs1 = 5'(i_rs1);  if_s.de_rs1 = 5'(i_rs1);
    if_f.de_rs2 = 5'(i_rs2);  if_s.de_rs2 = 5'(i_rs2);
    if_f.de_use_rs1 = i_u1;   if_s.de_use_rs1 = i_u1;
    if_f.de_use_rs2 = i_u2;   if_s.de_use_rs2 = i_u2;
    if_f.de_rd = 5'(i_rd);    if_s.de_rd = 5'(i_rd);
    if_f.de_reg_write = i_wr; if_s.de_reg_write = i_wr;
    if_f.de_mem_read = i_ld;  if_s.de_mem_read = i_ld;
    if_f.br_taken = i_br;     if_s.br_taken = i_br;
    if_f.mem_busy = i_busy;   if_s.mem_busy = i_busy;
  endtask

  task automatic check_outs(input int m, input logic sf, input logic sd, input logic fl,
                            input logic bub, input logic [31:0] sa, input logic [31:0] sb,
                            input logic [31:0] cnt);
    string p;
    p = (m == 0) ? "fwd" : "stl";
    chk({p, ".stall_fetch"},  32'(sf),  32'(e_stl[m] || i_busy));
    chk({p, ".stall_decode"}, 32'(sd),  32'(e_stl[m] || i_busy));
    chk({p, ".flush_decode"}, 32'(fl),  32'(e_fl));
    chk({p, ".bubble_ex"},    32'(bub), 32'((e_stl[m] || e_fl) && !i_busy));
    chk({p, ".fwd_a_sel"},    sa,  32'(m_sa[m]));
    chk({p, ".fwd_b_sel"},    sb,  32'(m_sb[m]));
    chk({p, ".stall_cycles"}, cnt, 32'(m_cnt[m]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".fwd.stall_fetch"}, 32'(if_f.stall_fetch), 0);
    chk({tag, ".fwd.stall_decode"}, 32'(if_f.stall_decode), 0);
    chk({tag, ".fwd.flush_decode"}, 32'(if_f.flush_decode), 0);
    chk({tag, ".fwd.bubble_ex"}, 32'(if_f.bubble_ex), 0);
    chk({tag, ".fwd.fwd_a_sel"}, 32'(if_f.fwd_a_sel), 0);
    chk({tag, ".fwd.fwd_b_sel"}, 32'(if_f.fwd_b_sel), 0);
    chk({tag, ".fwd.stall_cycles"}, 32'(if_f.stall_cycles), 0);
    chk({tag, ".stl.stall_fetch"}, 32'(if_s.stall_fetch), 0);
    chk({tag, ".stl.bubble_ex"}, 32'(if_s.bubble_ex), 0);
    chk({tag, ".stl.stall_cycles"}, 32'(if_s.stall_cycles), 0);
  endtask

  // One pipeline cycle: drive at the falling edge, check mid-low phase, advance model on the rising edge.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input bit ld, input bit br, input bit busy);
    i_v = v; i_rs1 = rs1; i_u1 = u1; i_rs2 = rs2; i_u2 = u2;
    i_rd = rd; i_wr = wr; i_ld = ld; i_br = br; i_busy = busy;
    drive();
    #1;
    e_fl = i_br && !i_busy;
    for (int m = 0; m < 2; m++) begin
      ya[m] = youngest(m, i_rs1, i_u1);
      yb[m] = youngest(m, i_rs2, i_u2);
      e_stl[m] = i_v && (blocks(m, ya[m]) || blocks(m, yb[m])) && !i_br && !i_busy;
    end
    check_outs(0, if_f.stall_fetch, if_f.stall_decode, if_f.flush_decode, if_f.bubble_ex,
               32'(if_f.fwd_a_sel), 32'(if_f.fwd_b_sel), 32'(if_f.stall_cycles));
    check_outs(1, if_s.stall_fetch, if_s.stall_decode, if_s.flush_decode, if_s.bubble_ex,
               32'(if_s.fwd_a_sel), 32'(if_s.fwd_b_sel), 32'(if_s.stall_cycles));
    $display("step %0d: v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d wr=%0b ld=%0b br=%0b busy=%0b stall=%0b/%0b",
             nstep, v, rs1, u1, rs2, u2, rd, wr, ld, br, busy, e_stl[0], e_stl[1]);
    nstep++;
    @(posedge clk);
    mdl_clock(0);
    mdl_clock(1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int snap;

  initial begin
    rst = 1'b1;
    i_v = 0; i_rs1 = 0; i_u1 = 0; i_rs2 = 0; i_u2 = 0;
    i_rd = 0; i_wr = 0; i_ld = 0; i_br = 0; i_busy = 0;
    drive();
    mdl_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // ALU RAW: x5 producer in EX forwards through select 1 with no stall.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 9, 1, 0, 0, 0);
    chk("t1.fwd_a_sel", 32'(if_f.fwd_a_sel), 1);
    chk("t1.stall_cycles", 32'(if_f.stall_cycles), 0);

    // Load-use on rs2: one stall, then the load forwards from select 2.
    idle(3);
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    step(1, 0, 0, 6, 1, 10, 1, 0, 0, 0);
    chk("t2.stall_cycles", 32'(if_f.stall_cycles), 1);
    chk("t2.fwd_b_sel_stalled", 32'(if_f.fwd_b_sel), 0);
    step(1, 0, 0, 6, 1, 10, 1, 0, 0, 0);
    chk("t2.fwd_b_sel", 32'(if_f.fwd_b_sel), 2);
    chk("t2.stall_cycles_after", 32'(if_f.stall_cycles), 1);

    // x0 never matches; an unused operand never matches.
    idle(3);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 11, 1, 0, 0, 0);
    chk("t3.x0_sel", 32'(if_f.fwd_a_sel), 0);
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 0, 0, 0, 12, 1, 0, 0, 0);
    chk("t3.unused_sel", 32'(if_f.fwd_a_sel), 0);

    // Stall-only: a producer in EX costs two cycles, none once it reaches write-back.
    idle(3);
    snap = m_cnt[1];
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 13, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 13, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 13, 1, 0, 0, 0);
    chk("t4.stl_stall_cycles", 32'(if_s.stall_cycles), 32'(snap + 2));
    chk("t4.fwd_sel_from_wb", 32'(if_f.fwd_a_sel), 3);

    // Taken branch during a load-use hazard: flush wins, the load's consumer never enters EX.
    idle(3);
    snap = m_cnt[0];
    step(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    step(1, 8, 1, 0, 0, 14, 1, 0, 1, 0);
    chk("t5.no_count", 32'(if_f.stall_cycles), 32'(snap));
    chk("t5.sel_after_flush", 32'(if_f.fwd_a_sel), 0);
    step(1, 8, 1, 0, 0, 14, 1, 0, 0, 0);
    chk("t5.fwd_a_sel", 32'(if_f.fwd_a_sel), 2);

    // Memory stall freezes everything; asynchronous reset mid-freeze clears all outputs.
    idle(3);
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 15, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 15, 1, 0, 0, 16, 1, 0, 1, 1);
      chk("t6.frozen_sel", 32'(if_f.fwd_a_sel), 1);
    end
    step(1, 15, 1, 0, 0, 16, 1, 0, 0, 0);
    chk("t6.resume_sel", 32'(if_f.fwd_a_sel), 1);
    i_busy = 1; i_v = 1; i_rs1 = 16; i_u1 = 1;
    drive();
    #2 rst = 1'b1;
    #1 chk_zero("t6.arst");
    @(posedge clk);
    #1 chk_zero("t6.arst_edge");
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();

    // Randomised traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end
    chk("rand.stl_saturated", 32'(if_s.stall_cycles), 32'(m_cnt[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
